// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults for the writeback queue.
//   DEPTH      - write-buffer entries (power of two, >= 2)
//   WIDTH      - register data width
//   AW         - register address width
//   wb_entry_t - one buffered write {rg, data} at the default widths
package wb_pkg;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int AW    = 5;

   typedef struct packed {
      logic [AW-1:0]    rg;
      logic [WIDTH-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: all non-clock signals of the writeback queue.
//   in_valid/in_reg/in_data/in_ready  - writeback request handshake
//   rf_stall                          - register file write blocked this cycle
//   RegWrite/WriteRegister/WriteData  - register file write port
//   ReadRegister1/2, rf_ReadData1/2   - read addresses and raw file data
//   ReadData1/2                       - read data after bypass
//   count                             - occupied entries
// modport slave is the queue; modport master is its environment.
interface wb_queue_if #(
   parameter int DEPTH = wb_pkg::DEPTH,
   parameter int WIDTH = wb_pkg::WIDTH,
   parameter int AW    = wb_pkg::AW
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic [AW-1:0]    in_reg;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             rf_stall;
   logic             RegWrite;
   logic [AW-1:0]    WriteRegister;
   logic [WIDTH-1:0] WriteData;
   logic [AW-1:0]    ReadRegister1;
   logic [AW-1:0]    ReadRegister2;
   logic [WIDTH-1:0] rf_ReadData1;
   logic [WIDTH-1:0] rf_ReadData2;
   logic [WIDTH-1:0] ReadData1;
   logic [WIDTH-1:0] ReadData2;
   logic [CW-1:0]    count;

   modport slave (
      input  in_valid, in_reg, in_data, rf_stall,
             ReadRegister1, ReadRegister2, rf_ReadData1, rf_ReadData2,
      output in_ready, RegWrite, WriteRegister, WriteData,
             ReadData1, ReadData2, count
   );

   modport master (
      output in_valid, in_reg, in_data, rf_stall,
             ReadRegister1, ReadRegister2, rf_ReadData1, rf_ReadData2,
      input  in_ready, RegWrite, WriteRegister, WriteData,
             ReadData1, ReadData2, count
   );
endinterface

// File: rtl/wb_bypass.sv
// wb_bypass: read-port bypass over the queued writes.
//   addr     - read address
//   rf_data  - raw register file data for addr
//   ent_rg   - entry register numbers, index 0 = head (oldest)
//   ent_data - entry data, same ordering
//   ent_occ  - entry occupied flags, same ordering
//   data     - 0 for addr 0, else newest matching entry, else rf_data
module wb_bypass #(
   parameter int DEPTH = wb_pkg::DEPTH,
   parameter int WIDTH = wb_pkg::WIDTH,
   parameter int AW    = wb_pkg::AW
) (
   input  logic [AW-1:0]                addr,
   input  logic [WIDTH-1:0]             rf_data,
   input  logic [DEPTH-1:0][AW-1:0]     ent_rg,
   input  logic [DEPTH-1:0][WIDTH-1:0]  ent_data,
   input  logic [DEPTH-1:0]             ent_occ,
   output logic [WIDTH-1:0]             data
);
   // Entries arrive oldest first, so the last match in the scan is the newest.
   always_comb begin
      data = rf_data;
      for (int i = 0; i < DEPTH; i++)
         if (ent_occ[i] && ent_rg[i] == addr) data = ent_data[i];
      if (addr == '0) data = '0;
   end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: circular write buffer between writeback and the register file,
// with read bypass of buffered writes.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - wb_queue_if.slave (request, write port, read ports, count)
module wb_queue #(
   parameter int DEPTH = wb_pkg::DEPTH,
   parameter int WIDTH = wb_pkg::WIDTH,
   parameter int AW    = wb_pkg::AW
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_queue_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [AW-1:0]    rg;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;
   logic            push, pop, nonempty;

   logic [DEPTH-1:0][AW-1:0]    ord_rg;
   logic [DEPTH-1:0][WIDTH-1:0] ord_data;
   logic [DEPTH-1:0]            ord_occ;

   assign nonempty     = (count != '0);
   // Readiness comes from state only; a pop in the same cycle does not help.
   assign bus.in_ready = (count < FULL);
   // Writes to register 0 are accepted but never stored.
   assign push         = bus.in_valid && bus.in_ready && (bus.in_reg != '0);
   assign pop          = nonempty && !bus.rf_stall;

   assign bus.RegWrite      = pop;
   assign bus.WriteRegister = nonempty ? mem[head].rg   : '0;
   assign bus.WriteData     = nonempty ? mem[head].data : '0;
   assign bus.count         = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; occupancy gates every use of it.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= '{rg: bus.in_reg, data: bus.in_data};
   end

   // Present entries oldest-first so the bypass priority is a simple scan.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ord
      assign ord_rg[i]   = mem[head + PW'(i)].rg;
      assign ord_data[i] = mem[head + PW'(i)].data;
      assign ord_occ[i]  = (CW'(i) < count);
   end

   wb_bypass #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_byp1 (
      .addr(bus.ReadRegister1), .rf_data(bus.rf_ReadData1),
      .ent_rg(ord_rg), .ent_data(ord_data), .ent_occ(ord_occ),
      .data(bus.ReadData1)
   );

   wb_bypass #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_byp2 (
      .addr(bus.ReadRegister2), .rf_data(bus.rf_ReadData2),
      .ent_rg(ord_rg), .ent_data(ord_data), .ent_occ(ord_occ),
      .data(bus.ReadData2)
   );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: random and directed stimulus against a queue-based model of
// the writeback buffer; outputs compared every falling clock edge.
module tb_wb_queue;
   import wb_pkg::*;

   logic clk = 0;
   logic rst_n = 0;
   int   checks = 0;
   int   failures = 0;

   wb_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus ();

   wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Model: pending writes, oldest at index 0.
   wb_entry_t q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) q.delete();
      else begin
         bit do_pop, do_acc;
         do_pop = (q.size() != 0) && !bus.rf_stall;
         do_acc = bus.in_valid && (q.size() < DEPTH);
         if (do_pop) void'(q.pop_front());
         if (do_acc && bus.in_reg != 0) q.push_back('{rg: bus.in_reg, data: bus.in_data});
      end
   end

   function automatic logic [WIDTH-1:0] model_rd(logic [AW-1:0] a, logic [WIDTH-1:0] rfd);
      logic [WIDTH-1:0] r;
      if (a == 0) return '0;
      r = rfd;
      foreach (q[i]) if (q[i].rg == a) r = q[i].data;
      return r;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model.
   always @(negedge clk) begin
      int n;
      n = q.size();
      chk("count", 64'(bus.count), 64'(n));
      chk("in_ready", 64'(bus.in_ready), 64'(n < DEPTH));
      chk("count_le_depth", 64'(bus.count <= DEPTH), 64'd1);
      chk("RegWrite", 64'(bus.RegWrite), 64'(n != 0 && !bus.rf_stall));
      chk("WriteRegister", 64'(bus.WriteRegister), n != 0 ? 64'(q[0].rg) : 64'd0);
      chk("WriteData", 64'(bus.WriteData), n != 0 ? 64'(q[0].data) : 64'd0);
      chk("ReadData1", 64'(bus.ReadData1), 64'(model_rd(bus.ReadRegister1, bus.rf_ReadData1)));
      chk("ReadData2", 64'(bus.ReadData2), 64'(model_rd(bus.ReadRegister2, bus.rf_ReadData2)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [AW-1:0] r, logic [WIDTH-1:0] d);
      bus.in_valid = 1;
      bus.in_reg   = r;
      bus.in_data  = d;
      tick();
      bus.in_valid = 0;
   endtask

   initial begin
      bus.in_valid = 0; bus.in_reg = 0; bus.in_data = 0; bus.rf_stall = 0;
      bus.ReadRegister1 = 0; bus.ReadRegister2 = 0;
      bus.rf_ReadData1 = 0; bus.rf_ReadData2 = 0;

      // Reset state
      bus.ReadRegister1 = 7; bus.rf_ReadData1 = 32'h1234;
      @(negedge clk);
      chk("rst_count", 64'(bus.count), 0);
      chk("rst_in_ready", 64'(bus.in_ready), 1);
      chk("rst_RegWrite", 64'(bus.RegWrite), 0);
      chk("rst_WriteRegister", 64'(bus.WriteRegister), 0);
      chk("rst_ReadData1", 64'(bus.ReadData1), 64'h1234);
      tick();
      rst_n = 1;
      bus.ReadRegister1 = 0; bus.rf_ReadData1 = 0;

      // Single write, one-cycle latency
      push(3, 32'hDEADBEEF);
      @(negedge clk);
      chk("lat_RegWrite", 64'(bus.RegWrite), 1);
      chk("lat_WriteRegister", 64'(bus.WriteRegister), 3);
      chk("lat_WriteData", 64'(bus.WriteData), 64'hDEADBEEF);
      tick();
      @(negedge clk);
      chk("lat_count_after", 64'(bus.count), 0);

      // Fill under stall, reject fifth, drain in order
      bus.rf_stall = 1;
      tick();
      for (int i = 1; i <= 4; i++) push(AW'(i), WIDTH'(32'h100 + i));
      @(negedge clk);
      chk("full_count", 64'(bus.count), 4);
      chk("full_in_ready", 64'(bus.in_ready), 0);
      bus.in_valid = 1; bus.in_reg = 9; bus.in_data = 32'h999;
      tick();
      bus.in_valid = 0;
      @(negedge clk);
      chk("full_reject", 64'(bus.count), 4);
      bus.rf_stall = 0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("drain_RegWrite", 64'(bus.RegWrite), 1);
         chk("drain_reg", 64'(bus.WriteRegister), 64'(k));
         chk("drain_data", 64'(bus.WriteData), 64'(32'h100 + k));
         @(negedge clk);
      end
      chk("drain_count", 64'(bus.count), 0);

      // Bypass picks newest matching entry
      tick();
      bus.rf_stall = 1;
      push(5, 32'h11);
      push(5, 32'h22);
      bus.ReadRegister1 = 5; bus.rf_ReadData1 = 32'h99;
      @(negedge clk);
      chk("byp_newest", 64'(bus.ReadData1), 64'h22);
      bus.rf_stall = 0;
      tick(); tick();
      @(negedge clk);
      chk("byp_drained", 64'(bus.ReadData1), 64'h99);

      // Register 0 write discarded; address 0 reads 0
      tick();
      push(0, 32'hFFFF);
      bus.ReadRegister2 = 0; bus.rf_ReadData2 = 32'hCAFE_F00D;
      @(negedge clk);
      chk("r0_count", 64'(bus.count), 0);
      chk("r0_RegWrite", 64'(bus.RegWrite), 0);
      chk("r0_ReadData2", 64'(bus.ReadData2), 0);

      // Mid-operation reset pulse discards pending entries
      tick();
      bus.rf_stall = 1;
      push(1, 32'hA); push(2, 32'hB); push(3, 32'hC);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("rstp_count", 64'(bus.count), 0);
      chk("rstp_RegWrite", 64'(bus.RegWrite), 0);
      chk("rstp_in_ready", 64'(bus.in_ready), 1);
      rst_n = 1;
      bus.rf_stall = 0;
      tick();
      @(negedge clk);
      chk("rstp_no_write", 64'(bus.RegWrite), 0);
      chk("rstp_count_after", 64'(bus.count), 0);

      // Concurrent push/pop with stall toggling (pointer wrap)
      tick();
      bus.rf_stall = 1;
      push(6, 32'h60); push(7, 32'h70);
      for (int i = 0; i < 10; i++) begin
         bus.rf_stall = (i % 3 == 2);
         bus.in_valid = 1;
         bus.in_reg   = AW'($urandom_range(1, 31));
         bus.in_data  = $urandom;
         tick();
      end
      bus.in_valid = 0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.in_valid      = ($urandom_range(0, 3) != 0);
         bus.in_reg        = AW'($urandom_range(0, 7));
         bus.in_data       = $urandom;
         bus.rf_stall      = ($urandom_range(0, 2) == 0);
         bus.ReadRegister1 = AW'($urandom_range(0, 7));
         bus.ReadRegister2 = AW'($urandom_range(0, 7));
         bus.rf_ReadData1  = $urandom;
         bus.rf_ReadData2  = $urandom;
         tick();
      end
      bus.in_valid = 0; bus.rf_stall = 0;
      repeat (6) tick();
      @(negedge clk);
      chk("final_empty", 64'(bus.count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: write-buffer entries, power of two, at least 2.
REQ-002 The block SHALL have parameter WIDTH, default 32: register data width.
REQ-003 The block SHALL have parameter AW, default 5: register address width (32 registers).
REQ-004 The block SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports in_valid in 1, in_reg in AW, in_data in WIDTH: write request from the writeback stage.
REQ-007 The block SHALL have port in_ready  out  1: the buffer can accept a request this cycle.
REQ-008 The block SHALL have port rf_stall  in  1: the register file must not be written this cycle.
REQ-009 The block SHALL have ports RegWrite out 1, WriteRegister out AW, WriteData out WIDTH: these drive the register file write port.
REQ-010 The block SHALL have ports ReadRegister1 in AW and ReadRegister2 in AW: read addresses, also driven to the register file.
REQ-011 The block SHALL have ports rf_ReadData1 in WIDTH and rf_ReadData2 in WIDTH: raw register file read data.
REQ-012 The block SHALL have ports ReadData1 out WIDTH and ReadData2 out WIDTH: read data after bypass.
REQ-013 The block SHALL have port count  out  clog2(DEPTH)+1: number of occupied entries.

Function
REQ-014 The block SHALL be a circular FIFO of {reg, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on in_valid or rf_stall.
REQ-016 An accepted request (in_valid && in_ready) with in_reg != 0 SHALL be stored at the tail on that clock edge.
REQ-017 An accepted request with in_reg == 0 SHALL be consumed and discarded; count SHALL be unchanged.
REQ-018 RegWrite SHALL be combinational (count != 0) && !rf_stall.
REQ-019 WriteRegister/WriteData SHALL show the head entry when count != 0, and 0 when empty.
REQ-020 On a clock edge with RegWrite == 1 the head SHALL pop.
REQ-021 Latency: a request accepted at edge N SHALL be presentable on RegWrite no earlier than the cycle after edge N; the block has no combinational in->out write path.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-023 When full, in_ready SHALL be 0 even if a pop occurs that cycle.
REQ-024 Bypass, per read port independently: address 0 SHALL return 0.
REQ-025 Bypass: otherwise, when one or more stored entries match the address, the port SHALL return the data of the newest matching entry (closest to tail), including the head being written this cycle.
REQ-026 Bypass: otherwise the port SHALL pass rf_ReadData through unchanged.
REQ-027 A request being enqueued in the same cycle SHALL NOT be visible to bypass until it is stored.
REQ-028 While rf_stall is held, entries SHALL be retained indefinitely and the block SHALL perform no pops.

Reset
REQ-029 When rst_n is low, pointers and count SHALL be cleared to 0 immediately (asynchronously).
REQ-030 During and after reset: RegWrite = 0, WriteRegister = 0, WriteData = 0, in_ready = 1, and ReadData passes rf_ReadData through (0 for address 0).
REQ-031 Reset asserted mid-operation SHALL discard all pending entries without issuing any register file write.
REQ-032 Entry storage contents need not be reset; bypass SHALL only consider occupied entries.

Structure
REQ-033 Package wb_pkg SHALL hold DEPTH, WIDTH and AW defaults and the entry typedef {reg, data}.
REQ-034 Sub-module wb_bypass SHALL implement the priority match of one read port and SHALL be instantiated twice.

Verification
REQ-035 Reset then push reg 3 = 0xDEADBEEF with rf_stall = 0: the next cycle shows RegWrite = 1, WriteRegister = 3, WriteData = 0xDEADBEEF; count returns to 0 after that edge.
REQ-036 rf_stall = 1, push 4 entries (regs 1..4): count = 4, in_ready = 0, and a 5th request is not accepted; release stall: writes 1, 2, 3, 4 issue in order on consecutive cycles.
REQ-037 With stall, push reg 5 = 0x11 then reg 5 = 0x22 and set ReadRegister1 = 5, rf_ReadData1 = 0x99: ReadData1 = 0x22; after both entries drain, ReadData1 = 0x99.
REQ-038 Push to reg 0 with data 0xFFFF: count stays 0 and RegWrite never asserts; ReadRegister2 = 0 returns 0 for any rf_ReadData2.
REQ-039 With 3 entries pending under stall, pulse rst_n low for a partial cycle: count = 0, RegWrite = 0, and no writes issue after release.
REQ-040 Push and pop in the same cycle for 10 cycles with stall toggling: verify pointer wrap and that count never exceeds DEPTH.
